// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC/instruction widths, reset vector and fetch FSM states.
// Pure declarations, no logic.
package cpu_pkg;
  localparam int PC_W    = 16;
  localparam int INSTR_W = 17;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DISCARD
  } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO with synchronous clear; head visible with zero latency.
// No internal backpressure: pushes when full and pops when empty are ignored.
module fetch_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  input  logic                   clear,
  output logic [W-1:0]           head_dat,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & ((count != DEPTH_C) | do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with prefetch buffer; one memory request outstanding, 1 instr per 2 cycles at unit latency.
// stall holds the buffer head; requests stop once buffer occupancy plus outstanding reaches DEPTH.
module fetch_unit #(
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter int              INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(cpu_pkg::RESET_PC),
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCSrc,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               stall,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [CW-1:0]   occ;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  entry_t          push_dat;
  entry_t          head_dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  // Only FETCH can issue, so the outstanding count is implicitly zero when checking room.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    imem_req     = 1'b0;
    push         = 1'b0;
    case (state)
      FETCH: begin
        if (!reset && !PCSrc && (occ < DEPTH_C)) begin
          imem_req  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_valid) begin
          push      = ~PCSrc;
          state_nxt = FETCH;
        end else if (PCSrc) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_valid) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
    if (PCSrc)     fetch_pc_nxt = branch_target;
    else if (push) fetch_pc_nxt = fetch_pc + PC_W'(1);
  end

  assign imem_addr   = imem_req ? fetch_pc : '0;
  assign push_dat    = '{instr: imem_rdata, pc: fetch_pc};
  assign instr_valid = ~fifo_empty;
  assign pop         = instr_valid & ~stall & ~PCSrc;
  assign instr_out   = head_dat.instr;
  assign instr_pc    = head_dat.pc;

  fetch_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .clear    (PCSrc),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .count    (occ)
  );
endmodule
